mem_arbiter: RTL and testbench

Two-master arbiter sharing the single memory port (ren/wen/addr/wdata/wmask/rdata/rd_valid) between the CPU (master 0) and a second bus master such as a DMA or video fetcher (master 1). It grants at most one access per cycle using round-robin priority and allows one outstanding read at a time. It routes returned read data only to the master that issued the read, and it times out reads that the memory never answers. It sits between the masters and the memory/peripheral decoder.

---
 rtl/mem_arbiter_pkg.sv | 13 +
 rtl/mem_arbiter_rr2.sv | 23 ++
 rtl/mem_arbiter.sv | 147 ++++++++++++++
 tb/tb_mem_arbiter.sv | 366 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arbiter_pkg.sv
// Shared state encoding and master ids for the two-master memory arbiter.
// The arbiter top and the round-robin picker both import this package.
package mem_arbiter_pkg;

  typedef enum logic {
    ARB_ST_IDLE    = 1'b0,
    ARB_ST_RD_PEND = 1'b1
  } arb_state_t;

  localparam logic ARB_M0 = 1'b0;
  localparam logic ARB_M1 = 1'b1;

endpackage

// File: rtl/mem_arbiter_rr2.sv
// Two-way round-robin picker: a lone requester wins, a tie goes to the
// master that was not granted last. Purely combinational.
import mem_arbiter_pkg::*;

module arb_rr2 (
  input  logic [1:0] req,
  input  logic       last_gnt,
  input  logic       en,
  output logic [1:0] gnt
);

  always_comb begin
    gnt = 2'b00;
    if (en) begin
      if (req == 2'b11) begin
        gnt = (last_gnt == ARB_M1) ? 2'b01 : 2'b10;
      end else begin
        gnt = req;
      end
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one memory port between two masters with round-robin grants,
// one outstanding read, owner-only read routing and a read timeout.
import mem_arbiter_pkg::*;

module mem_arbiter #(
  parameter int W       = 32,
  parameter int AW      = 16,
  parameter int TIMEOUT = 15
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          m0_ren,
  input  logic          m0_wen,
  input  logic [AW-1:0] m0_addr,
  input  logic [W-1:0]  m0_wdata,
  input  logic [3:0]    m0_wmask,
  output logic          m0_ack,
  output logic [W-1:0]  m0_rdata,
  output logic          m0_rd_valid,
  input  logic          m1_ren,
  input  logic          m1_wen,
  input  logic [AW-1:0] m1_addr,
  input  logic [W-1:0]  m1_wdata,
  input  logic [3:0]    m1_wmask,
  output logic          m1_ack,
  output logic [W-1:0]  m1_rdata,
  output logic          m1_rd_valid,
  output logic          mem_ren,
  output logic          mem_wen,
  output logic [AW-1:0] mem_addr,
  output logic [W-1:0]  mem_wdata,
  output logic [3:0]    mem_wmask,
  input  logic [W-1:0]  mem_rdata,
  input  logic          mem_rd_valid,
  output logic          timeout
);

  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  arb_state_t    state, state_nx;
  logic          owner, owner_nx;
  logic [CW-1:0] cnt, cnt_nx;
  logic          last_gnt, last_gnt_nx;

  logic [1:0]    req;
  logic [1:0]    gnt;
  logic          rd_done;
  logic          rd_tmo;
  logic          can_accept;
  logic          resp_valid;
  logic [W-1:0]  resp_data;

  assign req        = {m1_ren | m1_wen, m0_ren | m0_wen};
  assign rd_done    = (state == ARB_ST_RD_PEND) && mem_rd_valid;
  assign rd_tmo     = (state == ARB_ST_RD_PEND) && !mem_rd_valid && (cnt == CNT_LAST);
  // Gating with rst_n keeps every output low while reset is held.
  assign can_accept = rst_n && ((state == ARB_ST_IDLE) || rd_done);

  arb_rr2 u_rr (
    .req      (req),
    .last_gnt (last_gnt),
    .en       (can_accept),
    .gnt      (gnt)
  );

  always_comb begin
    mem_ren   = 1'b0;
    mem_wen   = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    mem_wmask = '0;
    if (gnt[0]) begin
      mem_wen   = m0_wen;
      mem_ren   = m0_ren & ~m0_wen;
      mem_addr  = m0_addr;
      mem_wdata = m0_wdata;
      mem_wmask = m0_wmask;
    end else if (gnt[1]) begin
      mem_wen   = m1_wen;
      mem_ren   = m1_ren & ~m1_wen;
      mem_addr  = m1_addr;
      mem_wdata = m1_wdata;
      mem_wmask = m1_wmask;
    end
  end

  assign m0_ack = gnt[0];
  assign m1_ack = gnt[1];

  assign resp_valid  = rst_n && (rd_done || rd_tmo);
  assign resp_data   = rd_tmo ? '0 : mem_rdata;
  assign m0_rd_valid = resp_valid && (owner == ARB_M0);
  assign m1_rd_valid = resp_valid && (owner == ARB_M1);
  assign m0_rdata    = m0_rd_valid ? resp_data : '0;
  assign m1_rdata    = m1_rd_valid ? resp_data : '0;
  assign timeout     = rst_n && rd_tmo;

  // A read completing and a new read being accepted in the same cycle
  // keeps the arbiter in RD_PEND with the new owner.
  always_comb begin
    state_nx    = state;
    owner_nx    = owner;
    cnt_nx      = cnt;
    last_gnt_nx = last_gnt;
    if (|gnt) begin
      last_gnt_nx = gnt[1];
    end
    if (state == ARB_ST_IDLE) begin
      if (mem_ren) begin
        state_nx = ARB_ST_RD_PEND;
        owner_nx = gnt[1];
        cnt_nx   = '0;
      end
    end else begin
      if (rd_done) begin
        cnt_nx = '0;
        if (mem_ren) begin
          state_nx = ARB_ST_RD_PEND;
          owner_nx = gnt[1];
        end else begin
          state_nx = ARB_ST_IDLE;
        end
      end else if (rd_tmo) begin
        state_nx = ARB_ST_IDLE;
        cnt_nx   = '0;
      end else begin
        cnt_nx = cnt + CW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= ARB_ST_IDLE;
      owner    <= ARB_M0;
      cnt      <= '0;
      last_gnt <= ARB_M1;
    end else begin
      state    <= state_nx;
      owner    <= owner_nx;
      cnt      <= cnt_nx;
      last_gnt <= last_gnt_nx;
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Scenario bench for mem_arbiter: expected read responses are queued when a
// read is granted and popped when a master sees rd_valid.
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        m0_ren, m0_wen, m1_ren, m1_wen;
  logic [15:0] m0_addr, m1_addr;
  logic [31:0] m0_wdata, m1_wdata;
  logic [3:0]  m0_wmask, m1_wmask;
  logic        m0_ack, m1_ack, m0_rd_valid, m1_rd_valid;
  logic [31:0] m0_rdata, m1_rdata;
  logic        mem_ren, mem_wen, mem_rd_valid, timeout;
  logic [15:0] mem_addr;
  logic [31:0] mem_wdata, mem_rdata;
  logic [3:0]  mem_wmask;
  logic [122:0] all_out;

  typedef struct {
    logic        id;
    logic [31:0] data;
  } exp_t;

  exp_t rdq[$];
  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  assign all_out = {m0_ack, m1_ack, m0_rd_valid, m1_rd_valid, m0_rdata, m1_rdata,
                    mem_ren, mem_wen, mem_addr, mem_wdata, mem_wmask, timeout};

  mem_arbiter #(.W(32), .AW(16), .TIMEOUT(15)) dut (
    .clk(clk), .rst_n(rst_n),
    .m0_ren(m0_ren), .m0_wen(m0_wen), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_wmask(m0_wmask), .m0_ack(m0_ack), .m0_rdata(m0_rdata), .m0_rd_valid(m0_rd_valid),
    .m1_ren(m1_ren), .m1_wen(m1_wen), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_wmask(m1_wmask), .m1_ack(m1_ack), .m1_rdata(m1_rdata), .m1_rd_valid(m1_rd_valid),
    .mem_ren(mem_ren), .mem_wen(mem_wen), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_wmask(mem_wmask), .mem_rdata(mem_rdata), .mem_rd_valid(mem_rd_valid),
    .timeout(timeout)
  );

  function automatic logic [31:0] mem_word(input logic [15:0] a);
    return {16'hA5A5, a};
  endfunction

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    m0_ren = 0; m0_wen = 0; m0_addr = '0; m0_wdata = '0; m0_wmask = '0;
    m1_ren = 0; m1_wen = 0; m1_addr = '0; m1_wdata = '0; m1_wmask = '0;
    mem_rd_valid = 0; mem_rdata = '0;
  endtask

  task automatic test_reset();
    for (int i = 0; i < 2; i++) begin
      next_cycle();
      rst_n = 0;
      m0_ren = 1; m0_addr = 16'h1234; m1_wen = 1; m1_addr = 16'h4321;
      m1_wdata = 32'hFFFF_0000; m1_wmask = 4'hF; mem_rd_valid = 1; mem_rdata = 32'h7777_7777;
      @(negedge clk);
      checks++;
      if (all_out !== '0) begin
        failures++;
        $display("[TB] FAIL reset_outputs cycle=%0d got=%h exp=0", i, all_out);
      end
    end
    next_cycle();
    rst_n = 1;
    idle_inputs();
    @(negedge clk);
    checks++;
    if (all_out !== '0) begin
      failures++;
      $display("[TB] FAIL idle_outputs got=%h exp=0", all_out);
    end
  endtask

  task automatic test_tie_after_reset();
    logic        nv;
    logic [31:0] nd;
    logic [1:0]  exp_ack;
    exp_t        e;
    int          seen;
    nv = 0; nd = '0; seen = 0;
    for (int k = 0; k < 6; k++) begin
      next_cycle();
      m0_ren = (k < 4); m0_addr = 16'h0020;
      m1_ren = (k < 4); m1_addr = 16'h0030;
      mem_rd_valid = nv; mem_rdata = nv ? nd : 32'h0;
      @(negedge clk);
      exp_ack = (k < 4) ? ((k % 2 == 0) ? 2'b01 : 2'b10) : 2'b00;
      checks++;
      if ({m1_ack, m0_ack} !== exp_ack) begin
        failures++;
        $display("[TB] FAIL tie_ack k=%0d got=%b exp=%b", k, {m1_ack, m0_ack}, exp_ack);
      end
      if (m0_rd_valid || m1_rd_valid) begin
        seen++;
        checks++;
        if (rdq.size() == 0) begin
          failures++;
          $display("[TB] FAIL tie_rd_unexpected k=%0d got=%b exp=00", k, {m1_rd_valid, m0_rd_valid});
        end else begin
          e = rdq.pop_front();
          if ({m1_rd_valid, m0_rd_valid} !== (e.id ? 2'b10 : 2'b01) ||
              (e.id ? m1_rdata : m0_rdata) !== e.data || (e.id ? m0_rdata : m1_rdata) !== 32'h0) begin
            failures++;
            $display("[TB] FAIL tie_rd k=%0d got vld=%b r0=%h r1=%h exp id=%0d data=%h",
                     k, {m1_rd_valid, m0_rd_valid}, m0_rdata, m1_rdata, e.id, e.data);
          end
        end
      end
      if (k < 4) begin
        e.id   = (k % 2 == 1);
        e.data = mem_word((k % 2 == 1) ? 16'h0030 : 16'h0020);
        rdq.push_back(e);
      end
      nv = mem_ren;
      nd = mem_word(mem_addr);
    end
    checks++;
    if (rdq.size() != 0 || seen != 4) begin
      failures++;
      $display("[TB] FAIL tie_rd_count got=%0d left=%0d exp=4 left=0", seen, rdq.size());
      rdq.delete();
    end
    idle_inputs();
  endtask

  task automatic test_lone_write();
    next_cycle();
    m0_wen = 1; m0_addr = 16'h0010; m0_wdata = 32'hDEAD_BEEF; m0_wmask = 4'b1111;
    @(negedge clk);
    checks++;
    if ({mem_wen, mem_ren, m0_ack, m1_ack} !== 4'b1010) begin
      failures++;
      $display("[TB] FAIL write_strobes got=%b exp=1010", {mem_wen, mem_ren, m0_ack, m1_ack});
    end
    checks++;
    if (mem_addr !== 16'h0010 || mem_wdata !== 32'hDEAD_BEEF || mem_wmask !== 4'hF) begin
      failures++;
      $display("[TB] FAIL write_payload got=%h/%h/%h exp=0010/deadbeef/f", mem_addr, mem_wdata, mem_wmask);
    end
    checks++;
    if ({m1_rd_valid, m1_rdata} !== 33'h0) begin
      failures++;
      $display("[TB] FAIL write_m1_quiet got=%b/%h exp=0/0", m1_rd_valid, m1_rdata);
    end
    next_cycle();
    idle_inputs();
  endtask

  task automatic test_routing();
    exp_t e;
    next_cycle();
    m1_ren = 1; m1_addr = 16'h0100;
    @(negedge clk);
    checks++;
    if (m1_ack !== 1'b1 || m0_ack !== 1'b0 || mem_ren !== 1'b1 || mem_addr !== 16'h0100) begin
      failures++;
      $display("[TB] FAIL route_accept got ack=%b%b ren=%b addr=%h exp 10/1/0100",
               m1_ack, m0_ack, mem_ren, mem_addr);
    end
    e.id = 1'b1; e.data = 32'h1234_5678;
    rdq.push_back(e);
    next_cycle();
    m1_ren = 0; mem_rd_valid = 1; mem_rdata = 32'h1234_5678;
    @(negedge clk);
    checks++;
    if (!m1_rd_valid || rdq.size() == 0) begin
      failures++;
      $display("[TB] FAIL route_vld got=%b exp=1", m1_rd_valid);
      rdq.delete();
    end else begin
      e = rdq.pop_front();
      if (m1_rdata !== e.data || m0_rd_valid !== 1'b0 || m0_rdata !== 32'h0) begin
        failures++;
        $display("[TB] FAIL route_data got m1=%h m0v=%b m0=%h exp m1=%h m0v=0 m0=0",
                 m1_rdata, m0_rd_valid, m0_rdata, e.data);
      end
    end
    next_cycle();
    idle_inputs();
  endtask

  task automatic test_timeout();
    exp_t e;
    next_cycle();
    m0_ren = 1; m0_addr = 16'h0040; mem_rdata = 32'hFFFF_FFFF;
    @(negedge clk);
    checks++;
    if (m0_ack !== 1'b1 || mem_ren !== 1'b1) begin
      failures++;
      $display("[TB] FAIL tmo_accept got ack=%b ren=%b exp 1/1", m0_ack, mem_ren);
    end
    e.id = 1'b0; e.data = 32'h0;
    rdq.push_back(e);
    for (int i = 1; i <= 18; i++) begin
      next_cycle();
      m0_ren = 0;
      m1_wen = (i == 15 || i == 16); m1_addr = 16'h0044; m1_wdata = 32'h0BAD_F00D; m1_wmask = 4'hF;
      mem_rd_valid = (i == 18);
      @(negedge clk);
      if (i < 15) begin
        checks++;
        if (m0_rd_valid !== 1'b0 || timeout !== 1'b0) begin
          failures++;
          $display("[TB] FAIL tmo_early i=%0d got vld=%b tmo=%b exp 0/0", i, m0_rd_valid, timeout);
        end
      end else if (i == 15) begin
        checks++;
        if (timeout !== 1'b1 || m0_rd_valid !== 1'b1 || m1_ack !== 1'b0 || rdq.size() == 0) begin
          failures++;
          $display("[TB] FAIL tmo_fire got tmo=%b vld=%b m1ack=%b exp 1/1/0", timeout, m0_rd_valid, m1_ack);
          rdq.delete();
        end else begin
          e = rdq.pop_front();
          if (m0_rdata !== e.data) begin
            failures++;
            $display("[TB] FAIL tmo_rdata got=%h exp=%h", m0_rdata, e.data);
          end
        end
      end else if (i == 16) begin
        checks++;
        if (m1_ack !== 1'b1 || mem_wen !== 1'b1 || timeout !== 1'b0) begin
          failures++;
          $display("[TB] FAIL tmo_after_write got ack=%b wen=%b tmo=%b exp 1/1/0", m1_ack, mem_wen, timeout);
        end
      end else if (i == 18) begin
        checks++;
        if ({m0_rd_valid, m1_rd_valid, timeout} !== 3'b000) begin
          failures++;
          $display("[TB] FAIL tmo_late_reply got=%b exp=000", {m0_rd_valid, m1_rd_valid, timeout});
        end
      end
    end
    idle_inputs();
  endtask

  task automatic test_blocked_pending();
    exp_t e;
    next_cycle();
    m0_ren = 1; m0_addr = 16'h0050;
    @(negedge clk);
    checks++;
    if (m0_ack !== 1'b1) begin
      failures++;
      $display("[TB] FAIL blk_accept got=%b exp=1", m0_ack);
    end
    e.id = 1'b0; e.data = 32'h5555_AAAA;
    rdq.push_back(e);
    for (int i = 1; i <= 5; i++) begin
      next_cycle();
      m0_ren = 0;
      m1_wen = (i <= 4); m1_addr = 16'h0060; m1_wdata = 32'hCAFE_F00D; m1_wmask = 4'b0011;
      mem_rd_valid = (i == 4); mem_rdata = 32'h5555_AAAA;
      @(negedge clk);
      checks++;
      if (i < 4) begin
        if (m1_ack !== 1'b0 || mem_wen !== 1'b0 || m0_rd_valid !== 1'b0) begin
          failures++;
          $display("[TB] FAIL blk_wait i=%0d got ack=%b wen=%b vld=%b exp 0/0/0", i, m1_ack, mem_wen, m0_rd_valid);
        end
      end else if (i == 4) begin
        if (m1_ack !== 1'b1 || mem_wen !== 1'b1 || mem_addr !== 16'h0060 ||
            mem_wdata !== 32'hCAFE_F00D || mem_wmask !== 4'b0011 || !m0_rd_valid || rdq.size() == 0) begin
          failures++;
          $display("[TB] FAIL blk_release got ack=%b wen=%b addr=%h wd=%h wm=%b vld=%b exp 1/1/0060/cafef00d/0011/1",
                   m1_ack, mem_wen, mem_addr, mem_wdata, mem_wmask, m0_rd_valid);
          rdq.delete();
        end else begin
          e = rdq.pop_front();
          if (m0_rdata !== e.data) begin
            failures++;
            $display("[TB] FAIL blk_rdata got=%h exp=%h", m0_rdata, e.data);
          end
        end
      end else begin
        if ({mem_ren, mem_wen, mem_addr, mem_wdata, mem_wmask} !== 54'h0) begin
          failures++;
          $display("[TB] FAIL blk_idle got=%b/%b/%h/%h/%h exp zeros", mem_ren, mem_wen, mem_addr, mem_wdata, mem_wmask);
        end
      end
    end
    idle_inputs();
  endtask

  task automatic test_reset_mid_read();
    exp_t        e;
    logic [31:0] nd;
    next_cycle();
    m1_ren = 1; m1_addr = 16'h0070;
    @(negedge clk);
    checks++;
    if (m1_ack !== 1'b1) begin
      failures++;
      $display("[TB] FAIL rst_mid_accept got=%b exp=1", m1_ack);
    end
    next_cycle();
    rst_n = 0; m0_ren = 1; m1_ren = 1; mem_rd_valid = 1; mem_rdata = 32'h0000_1234;
    @(negedge clk);
    checks++;
    if (all_out !== '0) begin
      failures++;
      $display("[TB] FAIL rst_mid_outputs got=%h exp=0", all_out);
    end
    next_cycle();
    rst_n = 1; m0_ren = 0; m1_ren = 0; mem_rd_valid = 1;
    @(negedge clk);
    checks++;
    if ({m0_rd_valid, m1_rd_valid, timeout} !== 3'b000) begin
      failures++;
      $display("[TB] FAIL rst_mid_stale got=%b exp=000", {m0_rd_valid, m1_rd_valid, timeout});
    end
    next_cycle();
    mem_rd_valid = 0;
    m0_ren = 1; m0_addr = 16'h0080; m1_ren = 1; m1_addr = 16'h0090;
    @(negedge clk);
    checks++;
    if ({m1_ack, m0_ack} !== 2'b01) begin
      failures++;
      $display("[TB] FAIL rst_mid_tie got=%b exp=01", {m1_ack, m0_ack});
    end
    e.id = 1'b0; e.data = mem_word(16'h0080);
    rdq.push_back(e);
    nd = mem_word(mem_addr);
    next_cycle();
    m0_ren = 0; m1_ren = 0; mem_rd_valid = 1; mem_rdata = nd;
    @(negedge clk);
    checks++;
    if (!m0_rd_valid || m1_rd_valid || rdq.size() == 0) begin
      failures++;
      $display("[TB] FAIL rst_mid_read got vld=%b%b exp=01", m1_rd_valid, m0_rd_valid);
      rdq.delete();
    end else begin
      e = rdq.pop_front();
      if (m0_rdata !== e.data) begin
        failures++;
        $display("[TB] FAIL rst_mid_rdata got=%h exp=%h", m0_rdata, e.data);
      end
    end
    next_cycle();
    idle_inputs();
  endtask

  initial begin
    rst_n = 0;
    idle_inputs();
    test_reset();
    test_tie_after_reset();
    test_lone_write();
    test_routing();
    test_timeout();
    test_blocked_pending();
    test_reset_mid_read();
    next_cycle();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
